result_matrix_writer: RTL and testbench



---
 rtl/matrix_pkg.sv | 23 ++
 rtl/result_matrix_writer_if.sv | 25 ++
 rtl/dot_product_accumulator.sv | 42 ++++
 rtl/result_matrix_writer.sv | 82 ++++++++
 tb/tb_result_matrix_writer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared types and default dimensions for the matrix-multiply datapath.
// The row/column fetcher and the result writer both derive their widths from these constants.
package matrix_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} writer_state_t;

  localparam int DEFAULT_A_ROWS    = 8;
  localparam int DEFAULT_B_ROWS    = 8;
  localparam int DEFAULT_B_COLUMNS = 8;
  localparam int DEFAULT_C_DEPTH   = 64;
  localparam int DEFAULT_MEM_WIDTH = 32;

  // Counters never shrink below one bit, even when a dimension is 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PRODUCT_W  = DEFAULT_MEM_WIDTH;
  localparam int K_CNT_W    = clog2_min1(DEFAULT_B_ROWS);
  localparam int ELEM_IDX_W = clog2_min1(DEFAULT_A_ROWS * DEFAULT_B_COLUMNS);
  localparam int C_ADDR_W   = clog2_min1(DEFAULT_C_DEPTH);

endpackage

// File: rtl/result_matrix_writer_if.sv
// Product stream in, C memory write port and status out.
// The product stream has no back-pressure: mult_done is a one-cycle strobe that is always accepted.
interface result_matrix_writer_if #(
  parameter int W  = 32,
  parameter int AW = 6
);
  logic          start;
  logic [W-1:0]  mult_out;
  logic          mult_done;
  logic          wr_en;
  logic [AW-1:0] wr_address_c;
  logic [W-1:0]  write_data_c;
  logic          busy;
  logic          done;

  modport master (
    output start, mult_out, mult_done,
    input  wr_en, wr_address_c, write_data_c, busy, done
  );

  modport slave (
    input  start, mult_out, mult_done,
    output wr_en, wr_address_c, write_data_c, busy, done
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums K consecutive products; sum_valid flags the K-th one, with sum = total including it.
// clear wins over valid, so a product arriving with clear is dropped.
module dot_product_accumulator
  import matrix_pkg::*;
#(
  parameter int WIDTH = DEFAULT_MEM_WIDTH,
  parameter int K     = DEFAULT_B_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             sum_valid,
  output logic [WIDTH-1:0] sum
);
  localparam int KW = clog2_min1(K);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  logic [WIDTH-1:0] acc;
  logic [KW-1:0]    k;
  logic             last_term;

  assign last_term = (k == K_LAST);
  assign sum       = acc + data;
  assign sum_valid = valid && !clear && last_term;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      k   <= '0;
    end else if (valid) begin
      if (last_term) begin
        acc <= '0;
        k   <= '0;
      end else begin
        acc <= sum;
        k   <= k + 1'b1;
      end
    end
  end
endmodule

// File: rtl/result_matrix_writer.sv
// Accumulates the product stream into C[i][j] and writes each element at i*COLUMNS + j.
// start restarts from element 0 at any time; done pulses for the single DONE cycle.
module result_matrix_writer
  import matrix_pkg::*;
#(
  parameter int MATRIX_A_ROWS      = DEFAULT_A_ROWS,
  parameter int MATRIX_B_ROWS      = DEFAULT_B_ROWS,
  parameter int MATRIX_B_COLUMNS   = DEFAULT_B_COLUMNS,
  parameter int MATRIX_C_MEM_DEPTH = DEFAULT_C_DEPTH,
  parameter int MATRIX_MEM_WIDTH   = DEFAULT_MEM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  result_matrix_writer_if.slave bus,
  output writer_state_t         state_dbg
);
  localparam int AW = clog2_min1(MATRIX_C_MEM_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(MATRIX_A_ROWS * MATRIX_B_COLUMNS - 1);

  writer_state_t               state, state_next;
  logic [AW-1:0]               elem_idx;
  logic                        acc_clear, acc_valid, sum_valid, last_write;
  logic [MATRIX_MEM_WIDTH-1:0] sum;
  logic                        wr_en_q;
  logic [AW-1:0]               wr_addr_q;
  logic [MATRIX_MEM_WIDTH-1:0] wr_data_q;

  // Outside RUN the accumulator is held clear, so stray strobes never leave residue.
  assign acc_clear  = bus.start || (state != RUN);
  assign acc_valid  = (state == RUN) && bus.mult_done && !bus.start;
  assign last_write = sum_valid && (elem_idx == LAST_IDX);

  dot_product_accumulator #(
    .WIDTH (MATRIX_MEM_WIDTH),
    .K     (MATRIX_B_ROWS)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clear     (acc_clear),
    .valid     (acc_valid),
    .data      (bus.mult_out),
    .sum_valid (sum_valid),
    .sum       (sum)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_write) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      elem_idx  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state   <= state_next;
      wr_en_q <= sum_valid;
      if (bus.start) begin
        elem_idx <= '0;
      end else if (sum_valid) begin
        wr_addr_q <= elem_idx;
        wr_data_q <= sum;
        elem_idx  <= last_write ? '0 : elem_idx + 1'b1;
      end
    end
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_address_c = wr_addr_q;
  assign bus.write_data_c = wr_data_q;
  assign bus.busy         = (state == RUN);
  assign bus.done         = (state == DONE);
  assign state_dbg        = state;
endmodule

// File: tb/tb_result_matrix_writer.sv
// Directed bench for result_matrix_writer: a K=2 instance and a K=1 instance, both 2x2 results,
// with a write scoreboard per instance fed from the stimulus and drained by a write monitor.
module tb_result_matrix_writer;
  import matrix_pkg::*;

  localparam int W  = 32;
  localparam int AW = 2;
  localparam int EW = AW + W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];

  writer_state_t state_a, state_b;

  result_matrix_writer_if #(.W(W), .AW(AW)) ia ();
  result_matrix_writer_if #(.W(W), .AW(AW)) ib ();

  result_matrix_writer #(
    .MATRIX_A_ROWS(2), .MATRIX_B_ROWS(2), .MATRIX_B_COLUMNS(2),
    .MATRIX_C_MEM_DEPTH(4), .MATRIX_MEM_WIDTH(W)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia.slave), .state_dbg(state_a));

  result_matrix_writer #(
    .MATRIX_A_ROWS(2), .MATRIX_B_ROWS(1), .MATRIX_B_COLUMNS(2),
    .MATRIX_C_MEM_DEPTH(4), .MATRIX_MEM_WIDTH(W)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib.slave), .state_dbg(state_b));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [EW-1:0] wr(input int addr, input logic [W-1:0] data);
    return {AW'(addr), data};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic md, input logic [W-1:0] v);
    if (sel == 0) begin
      ia.start = st; ia.mult_done = md; ia.mult_out = v;
    end else begin
      ib.start = st; ib.mult_done = md; ib.mult_out = v;
    end
  endtask

  task automatic pulse_start(input int sel, input logic md, input logic [W-1:0] v);
    drive(sel, 1'b1, md, v);
    tick();
    drive(sel, 1'b0, 1'b0, '0);
  endtask

  task automatic strobe(input int sel, input logic [W-1:0] v);
    drive(sel, 1'b0, 1'b1, v);
    tick();
    drive(sel, 1'b0, 1'b0, '0);
  endtask

  // ---------------- scoreboard / write monitors ----------------
  always @(negedge clk) begin
    if (!rst && ia.wr_en) begin
      checks++;
      assert (exp_q_a.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write_a got=%0h", {ia.wr_address_c, ia.write_data_c});
      end
      if (exp_q_a.size() > 0) begin
        automatic logic [EW-1:0] e = exp_q_a.pop_front();
        checks++;
        assert ({ia.wr_address_c, ia.write_data_c} === e) else begin
          failures++;
          $error("FAIL write_a got=%0h exp=%0h", {ia.wr_address_c, ia.write_data_c}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ib.wr_en) begin
      checks++;
      assert (exp_q_b.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write_b got=%0h", {ib.wr_address_c, ib.write_data_c});
      end
      if (exp_q_b.size() > 0) begin
        automatic logic [EW-1:0] e = exp_q_b.pop_front();
        checks++;
        assert ({ib.wr_address_c, ib.write_data_c} === e) else begin
          failures++;
          $error("FAIL write_b got=%0h exp=%0h", {ib.wr_address_c, ib.write_data_c}, e);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    rst = 1'b1;
    repeat (3) tick();

    // reset values
    check("rst_wr_en_a", 64'(ia.wr_en), 64'd0);
    check("rst_addr_a", 64'(ia.wr_address_c), 64'd0);
    check("rst_data_a", 64'(ia.write_data_c), 64'd0);
    check("rst_busy_a", 64'(ia.busy), 64'd0);
    check("rst_done_a", 64'(ia.done), 64'd0);
    check("rst_state_a", 64'(state_a), 64'(IDLE));
    check("rst_state_b", 64'(state_b), 64'(IDLE));
    rst = 1'b0;
    tick();

    // back-to-back strobes 1..8
    pulse_start(0, 1'b0, '0);
    check("busy_after_start", 64'(ia.busy), 64'd1);
    exp_q_a.push_back(wr(0, 3));  exp_q_a.push_back(wr(1, 7));
    exp_q_a.push_back(wr(2, 11)); exp_q_a.push_back(wr(3, 15));
    for (int v = 1; v <= 8; v++) begin
      strobe(0, W'(v));
      check($sformatf("b2b_wr_en_%0d", v), 64'(ia.wr_en), 64'((v % 2) == 0));
    end
    check("b2b_done", 64'(ia.done), 64'd1);
    check("b2b_busy_fell", 64'(ia.busy), 64'd0);
    check("b2b_state_done", 64'(state_a), 64'(DONE));
    tick();
    check("b2b_done_one_cycle", 64'(ia.done), 64'd0);
    check("b2b_state_idle", 64'(state_a), 64'(IDLE));
    check("b2b_queue_empty", 64'(exp_q_a.size()), 64'd0);

    // same stream with two idle cycles between strobes
    pulse_start(0, 1'b0, '0);
    exp_q_a.push_back(wr(0, 3));  exp_q_a.push_back(wr(1, 7));
    exp_q_a.push_back(wr(2, 11)); exp_q_a.push_back(wr(3, 15));
    for (int v = 1; v <= 8; v++) begin
      strobe(0, W'(v));
      check($sformatf("gap_wr_en_%0d", v), 64'(ia.wr_en), 64'((v % 2) == 0));
      tick();
      check($sformatf("gap_wr_en_low_%0d", v), 64'(ia.wr_en), 64'd0);
      tick();
    end
    check("gap_state_idle", 64'(state_a), 64'(IDLE));
    check("gap_queue_empty", 64'(exp_q_a.size()), 64'd0);

    // wrap-around addition
    pulse_start(0, 1'b0, '0);
    exp_q_a.push_back(wr(0, 32'h1));
    strobe(0, 32'hFFFF_FFFF);
    strobe(0, 32'h2);
    tick();
    check("ovf_queue_empty", 64'(exp_q_a.size()), 64'd0);

    // restart mid-run: a fresh start with a coincident strobe that must be ignored
    pulse_start(0, 1'b0, '0);
    exp_q_a.push_back(wr(0, 3));
    strobe(0, 1); strobe(0, 2); strobe(0, 3);
    pulse_start(0, 1'b1, 32'd99);
    check("restart_busy", 64'(ia.busy), 64'd1);
    exp_q_a.push_back(wr(0, 3));  exp_q_a.push_back(wr(1, 7));
    exp_q_a.push_back(wr(2, 11)); exp_q_a.push_back(wr(3, 15));
    for (int v = 1; v <= 8; v++) strobe(0, W'(v));
    check("restart_done", 64'(ia.done), 64'd1);
    tick();
    check("restart_queue_empty", 64'(exp_q_a.size()), 64'd0);

    // rst sampled on the edge that would issue the write of 7
    pulse_start(0, 1'b0, '0);
    exp_q_a.push_back(wr(0, 3));
    strobe(0, 1); strobe(0, 2); strobe(0, 3);
    rst = 1'b1;
    drive(0, 1'b0, 1'b1, 32'd4);
    tick();
    drive(0, 1'b0, 1'b0, '0);
    check("rstmid_wr_en", 64'(ia.wr_en), 64'd0);
    check("rstmid_addr", 64'(ia.wr_address_c), 64'd0);
    check("rstmid_data", 64'(ia.write_data_c), 64'd0);
    check("rstmid_busy", 64'(ia.busy), 64'd0);
    check("rstmid_done", 64'(ia.done), 64'd0);
    check("rstmid_state", 64'(state_a), 64'(IDLE));
    rst = 1'b0;
    tick();
    strobe(0, 32'd9);
    check("idle_strobe_wr_en", 64'(ia.wr_en), 64'd0);
    check("idle_strobe_state", 64'(state_a), 64'(IDLE));
    tick();
    check("rstmid_queue_empty", 64'(exp_q_a.size()), 64'd0);

    // K=1: start with a coincident strobe (start wins), then 5..8
    pulse_start(1, 1'b1, 32'd77);
    check("k1_busy", 64'(ib.busy), 64'd1);
    exp_q_b.push_back(wr(0, 5)); exp_q_b.push_back(wr(1, 6));
    exp_q_b.push_back(wr(2, 7)); exp_q_b.push_back(wr(3, 8));
    for (int v = 5; v <= 8; v++) begin
      strobe(1, W'(v));
      check($sformatf("k1_wr_en_%0d", v), 64'(ib.wr_en), 64'd1);
    end
    check("k1_done", 64'(ib.done), 64'd1);
    check("k1_busy_fell", 64'(ib.busy), 64'd0);
    tick();
    check("k1_state_idle", 64'(state_b), 64'(IDLE));
    check("k1_queue_empty", 64'(exp_q_b.size()), 64'd0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
